// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types and helpers for the keypad scan controller: FSM states,
// column priority encoding, row strobe encoding and the hex keymap.
package keypad_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Lowest-index active column wins; returns one-hot or zero.
    function automatic logic [3:0] prio_onehot(input logic [3:0] col);
        logic [3:0] res;
        res = 4'b0000;
        if (col[0]) begin
            res = 4'b0001;
        end else if (col[1]) begin
            res = 4'b0010;
        end else if (col[2]) begin
            res = 4'b0100;
        end else if (col[3]) begin
            res = 4'b1000;
        end else begin
            res = 4'b0000;
        end
        return res;
    endfunction

    function automatic logic [3:0] row_onehot(input logic [1:0] row_idx);
        logic [3:0] res;
        case (row_idx)
            2'd0:    res = 4'b0001;
            2'd1:    res = 4'b0010;
            2'd2:    res = 4'b0100;
            2'd3:    res = 4'b1000;
            default: res = 4'b0001;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] decode_key(input logic [1:0] row_idx,
                                              input logic [3:0] col_onehot);
        logic [3:0] res;
        case ({row_idx, col_onehot})
            6'b00_0001: res = 4'h1;
            6'b00_0010: res = 4'h2;
            6'b00_0100: res = 4'h3;
            6'b00_1000: res = 4'hA;
            6'b01_0001: res = 4'h4;
            6'b01_0010: res = 4'h5;
            6'b01_0100: res = 4'h6;
            6'b01_1000: res = 4'hB;
            6'b10_0001: res = 4'h7;
            6'b10_0010: res = 4'h8;
            6'b10_0100: res = 4'h9;
            6'b10_1000: res = 4'hC;
            6'b11_0001: res = 4'hE;
            6'b11_0010: res = 4'h0;
            6'b11_0100: res = 4'hF;
            6'b11_1000: res = 4'hD;
            default:    res = 4'h0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad matrix and display-digit signals of the scan controller.
interface keypad_scan_ctrl_if;
    logic [3:0] col;
    logic [3:0] row;
    logic       key_valid;
    logic [3:0] key_hex;
    logic [3:0] digit_new;
    logic [3:0] digit_old;

    modport master (
        input  col,
        output row,
        output key_valid,
        output key_hex,
        output digit_new,
        output digit_old
    );

    modport slave (
        output col,
        input  row,
        input  key_valid,
        input  key_hex,
        input  digit_new,
        input  digit_old
    );
endinterface

// File: rtl/keypad_scan_ctrl_sync2.sv
// Two-flop synchronizer bringing the asynchronous keypad columns into clk.
module keypad_scan_ctrl_sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Metastability chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= '0;
            sync_r <= '0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: row strobing, column debounce, one decode per press
// and the two-digit key history for the display path.
module keypad_scan_ctrl #(
    parameter int SCAN_DIV        = 4000,
    parameter int DEBOUNCE_CYCLES = 200000
) (
    input  logic                  clk,
    input  logic                  reset,
    keypad_scan_ctrl_if.master    kp
);
    import keypad_scan_ctrl_pkg::*;

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       col_s;
    logic [3:0]       col_pri_s;
    logic             col_any_s;
    logic             tick_s;
    logic             match_s;
    logic [3:0]       dec_s;

    state_t           state_r,     state_nxt_s;
    logic [DIV_W-1:0] div_r,       div_nxt_s;
    logic [CNT_W-1:0] cnt_r,       cnt_nxt_s;
    logic [1:0]       row_idx_r,   row_idx_nxt_s;
    logic [3:0]       col_sel_r,   col_sel_nxt_s;
    logic [3:0]       row_r,       row_nxt_s;
    logic             key_valid_r, key_valid_nxt_s;
    logic [3:0]       key_hex_r,   key_hex_nxt_s;
    logic [3:0]       digit_new_r, digit_new_nxt_s;
    logic [3:0]       digit_old_r, digit_old_nxt_s;

    keypad_scan_ctrl_sync2 #(.WIDTH(4)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kp.col),
        .q     (col_s)
    );

    assign col_pri_s = prio_onehot(col_s);
    assign col_any_s = |col_s;
    assign tick_s    = (state_r == SCAN) && (div_r == DIV_LAST);
    assign match_s   = (col_pri_s == col_sel_r);
    assign dec_s     = decode_key(row_idx_r, col_sel_r);

    // Next-state and output decode; the divider only runs in SCAN so every
    // return to SCAN starts a full scan period.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        row_idx_nxt_s   = row_idx_r;
        col_sel_nxt_s   = col_sel_r;
        key_valid_nxt_s = 1'b0;
        key_hex_nxt_s   = key_hex_r;
        digit_new_nxt_s = digit_new_r;
        digit_old_nxt_s = digit_old_r;
        div_nxt_s       = '0;

        case (state_r)
            SCAN: begin
                if (tick_s) begin
                    div_nxt_s = '0;
                    if (col_any_s) begin
                        col_sel_nxt_s = col_pri_s;
                        cnt_nxt_s     = '0;
                        state_nxt_s   = DEBOUNCE;
                    end else begin
                        row_idx_nxt_s = row_idx_r + 2'd1;
                    end
                end else begin
                    div_nxt_s = div_r + DIV_W'(1);
                end
            end
            DEBOUNCE: begin
                if (match_s) begin
                    if (cnt_r == CNT_LAST) begin
                        key_valid_nxt_s = 1'b1;
                        key_hex_nxt_s   = dec_s;
                        digit_old_nxt_s = digit_new_r;
                        digit_new_nxt_s = dec_s;
                        cnt_nxt_s       = '0;
                        state_nxt_s     = HELD;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = SCAN;
                end
            end
            HELD: begin
                if (!col_any_s) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = RELEASE;
                end else begin
                    state_nxt_s = HELD;
                end
            end
            RELEASE: begin
                if (col_any_s) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = HELD;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = SCAN;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                cnt_nxt_s   = '0;
                state_nxt_s = SCAN;
            end
        endcase

        row_nxt_s = row_onehot(row_idx_nxt_s);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= SCAN;
            div_r       <= '0;
            cnt_r       <= '0;
            row_idx_r   <= 2'd0;
            col_sel_r   <= 4'b0000;
            row_r       <= 4'b0001;
            key_valid_r <= 1'b0;
            key_hex_r   <= 4'h0;
            digit_new_r <= 4'h0;
            digit_old_r <= 4'h0;
        end else begin
            state_r     <= state_nxt_s;
            div_r       <= div_nxt_s;
            cnt_r       <= cnt_nxt_s;
            row_idx_r   <= row_idx_nxt_s;
            col_sel_r   <= col_sel_nxt_s;
            row_r       <= row_nxt_s;
            key_valid_r <= key_valid_nxt_s;
            key_hex_r   <= key_hex_nxt_s;
            digit_new_r <= digit_new_nxt_s;
            digit_old_r <= digit_old_nxt_s;
        end
    end

    assign kp.row       = row_r;
    assign kp.key_valid = key_valid_r;
    assign kp.key_hex   = key_hex_r;
    assign kp.digit_new = digit_new_r;
    assign kp.digit_old = digit_old_r;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural 4x4 keypad model.
module tb_keypad_scan_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   pulse_cnt;

    logic       press_en;
    logic       force_zero;
    logic [3:0] press_row;
    logic [3:0] press_col;

    keypad_scan_ctrl_if kif ();

    keypad_scan_ctrl #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif)
    );

    // Keypad: a pressed key connects its row strobe onto its column.
    assign kif.col = (press_en && !force_zero && (kif.row == press_row)) ? press_col : 4'b0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (kif.key_valid) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_key(input logic [3:0] r, input logic [3:0] c);
        press_row = r;
        press_col = c;
        press_en  = 1'b1;
    endtask

    task automatic release_key();
        press_en = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    task automatic wait_pulse(input int max_cycles, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (kif.key_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (kif.row !== 4'b0001) begin n_fail++; $display("FAIL reset_row got %b exp 0001", kif.row); end
        n_checks++; if (kif.key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", kif.key_valid); end
        n_checks++; if (kif.key_hex !== 4'h0) begin n_fail++; $display("FAIL reset_hex got %h exp 0", kif.key_hex); end
        n_checks++; if (kif.digit_new !== 4'h0) begin n_fail++; $display("FAIL reset_new got %h exp 0", kif.digit_new); end
        n_checks++; if (kif.digit_old !== 4'h0) begin n_fail++; $display("FAIL reset_old got %h exp 0", kif.digit_old); end
    endtask

    task automatic test_idle_scan();
        logic [3:0] exp_row;
        logic [1:0] idx;
        bit         bad_valid;
        press_en = 1'b0;
        do_reset();
        bad_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            idx     = 2'((k / 4) % 4);
            exp_row = 4'b0001 << idx;
            n_checks++;
            if (kif.row !== exp_row) begin
                n_fail++; $display("FAIL idle_row k=%0d got %b exp %b", k, kif.row, exp_row);
            end
            if (kif.key_valid !== 1'b0) bad_valid = 1'b1;
        end
        n_checks++; if (bad_valid) begin n_fail++; $display("FAIL idle_valid got pulse exp none"); end
        n_checks++; if (kif.digit_new !== 4'h0 || kif.digit_old !== 4'h0) begin
            n_fail++; $display("FAIL idle_digits got %h%h exp 00", kif.digit_old, kif.digit_new); end
    endtask

    task automatic test_press_5();
        bit seen;
        int base;
        bit moved;
        base = pulse_cnt;
        set_key(4'b0010, 4'b0010);
        wait_pulse(200, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL press5_timeout got none exp pulse"); end
        n_checks++; if (kif.key_hex !== 4'h5) begin n_fail++; $display("FAIL press5_hex got %h exp 5", kif.key_hex); end
        n_checks++; if (kif.digit_new !== 4'h5) begin n_fail++; $display("FAIL press5_new got %h exp 5", kif.digit_new); end
        n_checks++; if (kif.digit_old !== 4'h0) begin n_fail++; $display("FAIL press5_old got %h exp 0", kif.digit_old); end
        @(negedge clk);
        n_checks++; if (kif.key_valid !== 1'b0) begin n_fail++; $display("FAIL press5_pulse_width got %b exp 0", kif.key_valid); end
        repeat (20) @(negedge clk);
        n_checks++; if (pulse_cnt !== base + 1) begin n_fail++; $display("FAIL press5_count got %0d exp %0d", pulse_cnt - base, 1); end
        n_checks++; if (kif.row !== 4'b0010) begin n_fail++; $display("FAIL press5_row_held got %b exp 0010", kif.row); end
        press_en = 1'b0;
        moved = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (kif.row !== 4'b0010) moved = 1'b1;
        end
        n_checks++; if (moved) begin n_fail++; $display("FAIL press5_row_frozen got change exp 0010"); end
        @(negedge clk);
        n_checks++; if (kif.row !== 4'b0100) begin n_fail++; $display("FAIL press5_row_resume got %b exp 0100", kif.row); end
    endtask

    task automatic test_back_to_back();
        bit seen;
        set_key(4'b0100, 4'b0001);
        wait_pulse(200, seen);
        n_checks++; if (!seen || kif.key_hex !== 4'h7) begin n_fail++; $display("FAIL seq7_hex got %h seen=%0d exp 7", kif.key_hex, seen); end
        n_checks++; if (kif.digit_new !== 4'h7 || kif.digit_old !== 4'h5) begin
            n_fail++; $display("FAIL seq7_digits got %h%h exp 57", kif.digit_old, kif.digit_new); end
        release_key();
        set_key(4'b1000, 4'b1000);
        wait_pulse(200, seen);
        n_checks++; if (!seen || kif.key_hex !== 4'hD) begin n_fail++; $display("FAIL seqD_hex got %h seen=%0d exp D", kif.key_hex, seen); end
        n_checks++; if (kif.digit_new !== 4'hD || kif.digit_old !== 4'h7) begin
            n_fail++; $display("FAIL seqD_digits got %h%h exp 7D", kif.digit_old, kif.digit_new); end
        release_key();
    endtask

    task automatic test_bounce();
        bit seen;
        int base;
        base = pulse_cnt;
        set_key(4'b0001, 4'b0010);
        for (int i = 0; i < 10; i++) begin
            force_zero = (i % 2 == 0);
            repeat (3) @(negedge clk);
        end
        force_zero = 1'b0;
        n_checks++; if (pulse_cnt !== base) begin n_fail++; $display("FAIL bounce_pulses got %0d exp 0", pulse_cnt - base); end
        wait_pulse(200, seen);
        n_checks++; if (!seen || kif.key_hex !== 4'h2) begin n_fail++; $display("FAIL bounce_hex got %h seen=%0d exp 2", kif.key_hex, seen); end
        n_checks++; if (kif.digit_new !== 4'h2 || kif.digit_old !== 4'hD) begin
            n_fail++; $display("FAIL bounce_digits got %h%h exp D2", kif.digit_old, kif.digit_new); end
        repeat (20) @(negedge clk);
        n_checks++; if (pulse_cnt !== base + 1) begin n_fail++; $display("FAIL bounce_count got %0d exp 1", pulse_cnt - base); end
    endtask

    task automatic test_glitch();
        bit seen;
        int base;
        base = pulse_cnt;
        force_zero = 1'b1;
        repeat (3) @(negedge clk);
        force_zero = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++; if (pulse_cnt !== base) begin n_fail++; $display("FAIL glitch_pulses got %0d exp 0", pulse_cnt - base); end
        n_checks++; if (kif.row !== 4'b0001) begin n_fail++; $display("FAIL glitch_row got %b exp 0001", kif.row); end
        release_key();
        set_key(4'b0001, 4'b0010);
        wait_pulse(200, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL repress_timeout got none exp pulse"); end
        n_checks++; if (kif.digit_new !== 4'h2 || kif.digit_old !== 4'h2) begin
            n_fail++; $display("FAIL repress_digits got %h%h exp 22", kif.digit_old, kif.digit_new); end
        repeat (5) @(negedge clk);
        n_checks++; if (pulse_cnt !== base + 1) begin n_fail++; $display("FAIL repress_count got %0d exp 1", pulse_cnt - base); end
        release_key();
    endtask

    task automatic test_reset_mid_press();
        logic exp_v;
        // Key 1 held from reset: pulse lands on the 12th cycle after release.
        set_key(4'b0001, 4'b0001);
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_v = (k == 12);
            n_checks++;
            if (kif.key_valid !== exp_v) begin n_fail++; $display("FAIL latency k=%0d got %b exp %b", k, kif.key_valid, exp_v); end
        end
        n_checks++; if (kif.key_hex !== 4'h1) begin n_fail++; $display("FAIL latency_hex got %h exp 1", kif.key_hex); end
        do_reset();
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (kif.key_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b exp 0", kif.key_valid); end
        n_checks++; if (kif.row !== 4'b0001) begin n_fail++; $display("FAIL abort_row got %b exp 0001", kif.row); end
        n_checks++; if (kif.key_hex !== 4'h0) begin n_fail++; $display("FAIL abort_hex got %h exp 0", kif.key_hex); end
        n_checks++; if (kif.digit_new !== 4'h0 || kif.digit_old !== 4'h0) begin
            n_fail++; $display("FAIL abort_digits got %h%h exp 00", kif.digit_old, kif.digit_new); end
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_v = (k == 12);
            n_checks++;
            if (kif.key_valid !== exp_v) begin n_fail++; $display("FAIL abort_relatch k=%0d got %b exp %b", k, kif.key_valid, exp_v); end
        end
        release_key();
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        pulse_cnt  = 0;
        reset      = 1'b1;
        press_en   = 1'b0;
        force_zero = 1'b0;
        press_row  = 4'b0000;
        press_col  = 4'b0000;
        test_reset();
        test_idle_scan();
        test_press_5();
        test_back_to_back();
        test_bounce();
        test_glitch();
        test_reset_mid_press();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
